systolic_feed_ctrl: RTL and testbench

Sequencer between the UART byte/word receive path and the systolic multiply array. It captures matrix A (UNITS_X x K) and matrix B (K x UNITS_Y) from the RDATA/RVALID word stream, then on a START edge clears the array and drives the diagonally skewed operand wavefronts onto IP1/IP2. It holds the array enabled until partial sums drain, then pulses DONE and rearms for the next load.

---
 rtl/systolic_feed_ctrl.sv | 146 ++++++++++++++
 tb/tb_systolic_feed_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feed_ctrl.sv
// rtl/systolic_feed_ctrl.sv - operand capture and skewed wavefront sequencer for a systolic multiply array
module systolic_feed_ctrl #(
    parameter int Bitwidth = 16,
    parameter int UNITS_X  = 3,
    parameter int UNITS_Y  = 3,
    parameter int K        = 3
) (
    input  logic                        CLK,
    input  logic                        CPU_RESETN,
    input  logic [Bitwidth-1:0]         RDATA,
    input  logic                        RVALID,
    input  logic                        START,
    output logic [Bitwidth*UNITS_X-1:0] IP1,
    output logic [Bitwidth*UNITS_Y-1:0] IP2,
    output logic                        EN,
    output logic                        CLR,
    output logic                        LOADED,
    output logic                        BUSY,
    output logic                        DONE
);
    localparam int NA      = UNITS_X * K;
    localparam int NB      = K * UNITS_Y;
    localparam int TOTAL   = NA + NB;
    localparam int MAXU    = (UNITS_X > UNITS_Y) ? UNITS_X : UNITS_Y;
    localparam int T_FEED  = K + MAXU - 1;
    localparam int T_DRAIN = UNITS_X + UNITS_Y - 1;
    localparam int PMAX    = (T_FEED > T_DRAIN) ? T_FEED : T_DRAIN;
    localparam int WCW     = $clog2(TOTAL + 1);
    localparam int PCW     = $clog2(PMAX + 1);

    localparam logic [2:0] S_LOAD  = 3'd0;
    localparam logic [2:0] S_READY = 3'd1;
    localparam logic [2:0] S_CLEAR = 3'd2;
    localparam logic [2:0] S_FEED  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;

    logic [2:0]                  state;
    logic [WCW-1:0]              wcnt;
    logic [PCW-1:0]              pcnt;
    logic [PCW-1:0]              step;
    logic                        start_q;
    logic [Bitwidth-1:0]         a_mem [NA];
    logic [Bitwidth-1:0]         b_mem [NB];
    logic [Bitwidth*UNITS_X-1:0] ip1_step;
    logic [Bitwidth*UNITS_Y-1:0] ip2_step;

    // Storage is flattened row-major so the word counter addresses it directly.
    always_ff @(posedge CLK) begin
        if (state == S_LOAD && RVALID) begin
            for (int n = 0; n < NA; n++)
                if (wcnt == WCW'(n)) a_mem[n] <= RDATA;
            for (int n = 0; n < NB; n++)
                if (wcnt == WCW'(NA + n)) b_mem[n] <= RDATA;
        end
    end

    // pcnt holds the index of the wavefront being prepared for the next cycle.
    always_comb begin
        step     = (state == S_CLEAR) ? '0 : pcnt;
        ip1_step = '0;
        ip2_step = '0;
        for (int i = 0; i < UNITS_X; i++)
            for (int k = 0; k < K; k++)
                if (int'(step) == i + k)
                    ip1_step[i*Bitwidth +: Bitwidth] = a_mem[i*K + k];
        for (int j = 0; j < UNITS_Y; j++)
            for (int k = 0; k < K; k++)
                if (int'(step) == j + k)
                    ip2_step[j*Bitwidth +: Bitwidth] = b_mem[k*UNITS_Y + j];
    end

    always_ff @(posedge CLK or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state   <= S_LOAD;
            wcnt    <= '0;
            pcnt    <= '0;
            start_q <= 1'b0;
            IP1     <= '0;
            IP2     <= '0;
            EN      <= 1'b0;
            CLR     <= 1'b0;
            LOADED  <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            start_q <= START;
            CLR     <= 1'b0;
            DONE    <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (RVALID) begin
                        wcnt <= wcnt + 1'b1;
                        if (wcnt == WCW'(TOTAL - 1)) begin
                            state  <= S_READY;
                            LOADED <= 1'b1;
                        end
                    end
                end
                S_READY: begin
                    if (START && !start_q) begin
                        state <= S_CLEAR;
                        CLR   <= 1'b1;
                        BUSY  <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    IP1   <= ip1_step;
                    IP2   <= ip2_step;
                    EN    <= 1'b1;
                    pcnt  <= PCW'(1);
                    state <= S_FEED;
                end
                S_FEED: begin
                    if (pcnt == PCW'(T_FEED)) begin
                        IP1   <= '0;
                        IP2   <= '0;
                        pcnt  <= PCW'(1);
                        state <= S_DRAIN;
                    end else begin
                        IP1  <= ip1_step;
                        IP2  <= ip2_step;
                        pcnt <= pcnt + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (pcnt == PCW'(T_DRAIN)) begin
                        EN    <= 1'b0;
                        DONE  <= 1'b1;
                        state <= S_FIN;
                    end else begin
                        pcnt <= pcnt + 1'b1;
                    end
                end
                S_FIN: begin
                    BUSY   <= 1'b0;
                    LOADED <= 1'b0;
                    wcnt   <= '0;
                    pcnt   <= '0;
                    state  <= S_LOAD;
                end
                default: state <= S_LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// tb/tb_systolic_feed_ctrl.sv - directed self-checking bench for systolic_feed_ctrl
module tb_systolic_feed_ctrl;
    logic        CLK;
    logic        CPU_RESETN;
    logic [15:0] RDATA;
    logic        RVALID;
    logic        START;
    logic [47:0] IP1;
    logic [47:0] IP2;
    logic        EN, CLR, LOADED, BUSY, DONE;

    systolic_feed_ctrl #(.Bitwidth(16), .UNITS_X(3), .UNITS_Y(3), .K(3)) dut (
        .CLK(CLK), .CPU_RESETN(CPU_RESETN), .RDATA(RDATA), .RVALID(RVALID), .START(START),
        .IP1(IP1), .IP2(IP2), .EN(EN), .CLR(CLR), .LOADED(LOADED), .BUSY(BUSY), .DONE(DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    int exp_ip1 [5][3] = '{'{1,0,0}, '{2,4,0}, '{3,5,7}, '{0,6,8}, '{0,0,9}};
    int exp_ip2 [5][3] = '{'{10,0,0}, '{13,11,0}, '{16,14,12}, '{0,17,15}, '{0,0,18}};
    int exp_c   [3][3] = '{'{84,90,96}, '{201,216,231}, '{318,342,366}};

    // Behavioural 3x3 output-stationary array driven by the DUT outputs
    int ar [3][3];
    int br [3][3];
    int acc [3][3];

    logic [15:0] obs1 [10][3];
    logic [15:0] obs2 [10][3];
    int  en_cnt, en_breaks, clr_extra;
    bit  done_seen, done_prev_en, done_en, prev_en;
    bit  post_loaded, post_busy, post_done;

    task automatic model_step();
        if (CLR) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++) begin
                    ar[i][j] = 0; br[i][j] = 0; acc[i][j] = 0;
                end
        end else if (EN) begin
            for (int i = 2; i >= 0; i--)
                for (int j = 2; j >= 0; j--) begin
                    ar[i][j] = (j == 0) ? int'(IP1[i*16 +: 16]) : ar[i][j-1];
                    br[i][j] = (i == 0) ? int'(IP2[j*16 +: 16]) : br[i-1][j];
                    acc[i][j] = acc[i][j] + ar[i][j] * br[i][j];
                end
        end
    endtask

    task automatic load_seq(input int base, input int n);
        for (int w = 0; w < n; w++) begin
            RDATA  = 16'(base + w);
            RVALID = 1'b1;
            @(negedge CLK);
        end
        RVALID = 1'b0;
    endtask

    task automatic run_once(input bit inject);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        checks++;
        if (CLR !== 1'b1 || EN !== 1'b0 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL clr_cycle: CLR=%b EN=%b BUSY=%b expected 1 0 1", CLR, EN, BUSY);
        end
        model_step();
        en_cnt = 0; en_breaks = 0; clr_extra = 0;
        done_seen = 0; done_prev_en = 0; done_en = 0; prev_en = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            model_step();
            if (CLR) clr_extra++;
            if (EN) begin
                if (en_cnt < 10)
                    for (int l = 0; l < 3; l++) begin
                        obs1[en_cnt][l] = IP1[l*16 +: 16];
                        obs2[en_cnt][l] = IP2[l*16 +: 16];
                    end
                if (en_cnt > 0 && !prev_en) en_breaks++;
                en_cnt++;
            end
            if (inject && c < 5) begin
                RVALID = 1'b1;
                RDATA  = 16'(16'h0F00 + c);
            end else begin
                RVALID = 1'b0;
            end
            if (DONE) begin
                done_seen    = 1;
                done_prev_en = prev_en;
                done_en      = EN;
                break;
            end
            prev_en = EN;
        end
        RVALID = 1'b0;
        @(negedge CLK);
        post_loaded = LOADED;
        post_busy   = BUSY;
        post_done   = DONE;
    endtask

    task automatic test_reset();
        CPU_RESETN = 1'b0; START = 1'b0; RVALID = 1'b0; RDATA = '0;
        repeat (2) @(negedge CLK);
        checks++;
        if (IP1 !== '0 || IP2 !== '0) begin
            errors++;
            $display("FAIL reset_ip: IP1=%h IP2=%h expected 0", IP1, IP2);
        end
        checks++;
        if ({EN, CLR, LOADED, BUSY, DONE} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: EN CLR LOADED BUSY DONE=%b expected 00000", {EN, CLR, LOADED, BUSY, DONE});
        end
        CPU_RESETN = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_start_gating();
        bit bad;
        load_seq(1, 17);
        checks++;
        if (LOADED !== 1'b0) begin
            errors++;
            $display("FAIL loaded_17: LOADED=%b expected 0", LOADED);
        end
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        bad = 0;
        repeat (3) begin
            @(negedge CLK);
            if (CLR || EN || BUSY) bad = 1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL early_start: activity seen=%b expected 0", bad);
        end
        START = 1'b1;
        load_seq(18, 1);
        checks++;
        if (LOADED !== 1'b1) begin
            errors++;
            $display("FAIL loaded_18: LOADED=%b expected 1", LOADED);
        end
        bad = 0;
        repeat (4) begin
            @(negedge CLK);
            if (CLR || EN || BUSY) bad = 1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL held_start: activity seen=%b expected 0", bad);
        end
        START = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_feed();
        run_once(0);
        for (int s = 0; s < 5; s++)
            for (int l = 0; l < 3; l++) begin
                checks++;
                if (int'(obs1[s][l]) !== exp_ip1[s][l] || int'(obs2[s][l]) !== exp_ip2[s][l]) begin
                    errors++;
                    $display("FAIL feed_step%0d_lane%0d: IP1=%0d IP2=%0d expected %0d %0d",
                             s, l, obs1[s][l], obs2[s][l], exp_ip1[s][l], exp_ip2[s][l]);
                end
            end
        for (int s = 5; s < 10; s++) begin
            checks++;
            if ({obs1[s][0], obs1[s][1], obs1[s][2], obs2[s][0], obs2[s][1], obs2[s][2]} !== '0) begin
                errors++;
                $display("FAIL drain_zero%0d: operands nonzero during drain, expected 0", s);
            end
        end
        checks++;
        if (en_cnt !== 10 || en_breaks !== 0) begin
            errors++;
            $display("FAIL en_window: count=%0d breaks=%0d expected 10 0", en_cnt, en_breaks);
        end
        checks++;
        if (clr_extra !== 0) begin
            errors++;
            $display("FAIL clr_once: extra CLR cycles=%0d expected 0", clr_extra);
        end
        checks++;
        if (!done_seen || !done_prev_en || done_en) begin
            errors++;
            $display("FAIL done_timing: seen=%b prev_en=%b en=%b expected 1 1 0", done_seen, done_prev_en, done_en);
        end
        checks++;
        if (post_loaded !== 1'b0 || post_busy !== 1'b0 || post_done !== 1'b0) begin
            errors++;
            $display("FAIL post_done: LOADED=%b BUSY=%b DONE=%b expected 0 0 0", post_loaded, post_busy, post_done);
        end
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (acc[i][j] !== exp_c[i][j]) begin
                    errors++;
                    $display("FAIL result_c%0d%0d: got %0d expected %0d", i, j, acc[i][j], exp_c[i][j]);
                end
            end
    endtask

    task automatic test_extra_words();
        load_seq(1, 18);
        load_seq(200, 5);
        checks++;
        if (LOADED !== 1'b1 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL ready_burst: LOADED=%b BUSY=%b expected 1 0", LOADED, BUSY);
        end
        run_once(1);
        for (int s = 0; s < 5; s++) begin
            checks++;
            if (int'(obs1[s][2]) !== exp_ip1[s][2] || int'(obs2[s][0]) !== exp_ip2[s][0]) begin
                errors++;
                $display("FAIL extra_step%0d: IP1.2=%0d IP2.0=%0d expected %0d %0d",
                         s, obs1[s][2], obs2[s][0], exp_ip1[s][2], exp_ip2[s][0]);
            end
        end
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (acc[2][j] !== exp_c[2][j]) begin
                errors++;
                $display("FAIL extra_result_c2%0d: got %0d expected %0d", j, acc[2][j], exp_c[2][j]);
            end
        end
        checks++;
        if (!done_seen || en_cnt !== 10) begin
            errors++;
            $display("FAIL extra_run: done=%b en_count=%0d expected 1 10", done_seen, en_cnt);
        end
        load_seq(19, 18);
        run_once(0);
        checks++;
        if (obs1[0][0] !== 16'd19 || obs2[0][0] !== 16'd28 || obs1[4][2] !== 16'd27 || obs2[4][2] !== 16'd36) begin
            errors++;
            $display("FAIL reload_word0: IP1 %0d/%0d IP2 %0d/%0d expected 19/27 28/36",
                     obs1[0][0], obs1[4][2], obs2[0][0], obs2[4][2]);
        end
    endtask

    task automatic test_reset_mid_feed();
        bit bad;
        load_seq(1, 18);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if (EN !== 1'b1 || IP1[32 +: 16] !== 16'd7) begin
            errors++;
            $display("FAIL step2_pre_reset: EN=%b IP1.2=%0d expected 1 7", EN, IP1[32 +: 16]);
        end
        CPU_RESETN = 1'b0;
        #1;
        checks++;
        if (IP1 !== '0 || IP2 !== '0 || {EN, CLR, LOADED, BUSY, DONE} !== 5'b0) begin
            errors++;
            $display("FAIL async_reset: IP1=%h IP2=%h ctrl=%b expected 0",
                     IP1, IP2, {EN, CLR, LOADED, BUSY, DONE});
        end
        bad = 0;
        repeat (2) begin
            @(negedge CLK);
            if (DONE) bad = 1;
        end
        CPU_RESETN = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            if (DONE || BUSY || EN) bad = 1;
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL no_done_after_abort: activity seen=%b expected 0", bad);
        end
        load_seq(1, 18);
        run_once(0);
        checks++;
        if (!done_seen || en_cnt !== 10 || en_breaks !== 0) begin
            errors++;
            $display("FAIL rerun: done=%b en_count=%0d breaks=%0d expected 1 10 0", done_seen, en_cnt, en_breaks);
        end
        for (int j = 0; j < 3; j++) begin
            checks++;
            if (acc[0][j] !== exp_c[0][j]) begin
                errors++;
                $display("FAIL rerun_result_c0%0d: got %0d expected %0d", j, acc[0][j], exp_c[0][j]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_start_gating();
        test_feed();
        test_extra_words();
        test_reset_mid_feed();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
